axi4_lite_slave_responder: RTL and testbench
============================================

Name: axi4_lite_slave_responder

Overview:
- Parametrised AXI4-Lite slave endpoint with an internal word-addressed register memory.
- Programmable per-channel ready-delay injection (clamped to MAX_DELAY_VALUE).
- Address decode with DECERR/SLVERR responses, byte strobes, optional protection checking.
- Used as the synthesisable DUT-side responder behind the slave agent, and as a reference memory for master-side tests.

Parameters:
- ADDRESS_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; 32 or 64 only.
- MEM_DEPTH, 16, number of DATA_WIDTH words; power of two, 2..1024.
- BASE_ADDR, 0, byte address of word 0; aligned to MEM_DEPTH*DATA_WIDTH/8.
- DELAY_WIDTH, 5, width of delay config inputs.
- MAX_DELAY_VALUE, 15, clamp applied to configured delays.
- PROT_CHECK, 0, 1 = reject non-secure accesses (prot[1]=1) with SLVERR.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  reset; synchronous, active-high.
- cfg_write_ready_delay  in  DELAY_WIDTH  cycles before awready/wready.
- cfg_read_ready_delay  in  DELAY_WIDTH  cycles before arready.
- awaddr  in  ADDRESS_WIDTH  write address.
- awprot  in  3  write protection.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: 00 OKAY, 10 SLVERR, 11 DECERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDRESS_WIDTH  read address.
- arprot  in  3  read protection.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

Behaviour:
- Reset (areset=1 at an aclk edge):
  - All ready/valid outputs 0; bresp=00, rresp=00, rdata=0.
  - Memory cleared to 0; both FSMs return to IDLE.
  - Any in-flight transaction is abandoned: no partial write, no response.
- All outputs are registered. Write and read FSMs run independently and concurrently.
- Delay value D = min(cfg, MAX_DELAY_VALUE), sampled on the edge leaving IDLE; cfg changes mid-transaction are ignored.
- Decode:
  - off = addr - BASE_ADDR; idx = off >> log2(DATA_WIDTH/8).
  - off >= MEM_DEPTH*DATA_WIDTH/8, or addr < BASE_ADDR -> DECERR.
  - Otherwise low address bits not word-aligned -> SLVERR.
  - Otherwise PROT_CHECK=1 and prot[1]=1 -> SLVERR.
  - Otherwise OKAY.
  - Precedence: DECERR > misaligned SLVERR > prot SLVERR.
- Write FSM: W_IDLE -> W_DELAY -> W_ACCEPT -> W_RESP.
  - W_IDLE: wait for awvalid && wvalid in the same cycle. A lone awvalid or wvalid is not accepted.
  - W_DELAY: count D cycles; skipped when D=0.
  - W_ACCEPT: awready=wready=1 for exactly one cycle. Capture addr, data, strb and prot. On OKAY, write byte lanes whose wstrb bit is 1; on error, memory is unchanged.
  - W_RESP: bvalid=1 with bresp; hold stable until bready; return to W_IDLE on the handshake edge.
  - Latency with both valids first high in cycle 0: awready/wready in cycle 1+D, bvalid from cycle 2+D.
- Read FSM: R_IDLE -> R_DELAY -> R_ACCEPT -> R_RESP.
  - Same arvalid/D/arready timing as the write channel.
  - R_ACCEPT: arready=1 for one cycle; decode; load rdata with mem[idx] on OKAY, 0 on error.
  - R_RESP: rvalid=1; rdata/rresp held stable until rready; then R_IDLE.
- Simultaneous events:
  - Memory reads occur in the R_ACCEPT cycle; writes commit on the W_ACCEPT edge.
  - Read and write accepted in the same cycle to the same word: the read returns the pre-write value.
  - A read accepted in any later cycle sees the new value.
- Back-pressure: bready/rready held low indefinitely keeps the FSM in RESP; no further accept on that channel. The other channel is unaffected.
- wstrb=0 with OKAY decode: OKAY response, memory unchanged.

Test Plan:
- Write 0xDEADBEEF to 0x4, wstrb=0xF, delay 0, then read 0x4 -> awready/wready 1 cycle after valids, bvalid next cycle with OKAY; rdata=0xDEADBEEF, rresp=00.
- cfg_write_ready_delay=31 (MAX 15), write to 0x8 -> awready first high 16 cycles after valids; bvalid the following cycle.
- Write 0x11223344 to 0x0, then 0xAABBCCDD with wstrb=0x5 -> read 0x0 returns 0x11BB33DD.
- Access 0x40 (MEM_DEPTH=16) -> DECERR; 0x2 -> SLVERR; PROT_CHECK=1 with awprot=3'b010 -> SLVERR; memory unchanged in all three cases.
- Write and read to 0xC accepted in the same cycle (old 0x0, new 0x55) -> read returns 0x0; next read returns 0x55.
- bready low for 10 cycles while a read completes -> bvalid/bresp stable for all 10 cycles; R channel completes normally.
- areset asserted in W_DELAY -> all outputs 0 next cycle, no bvalid, memory 0.

Source files
------------

// File: rtl/axi4_lite_slave_responder.sv
// AXI4-Lite slave endpoint backed by a word-addressed register memory, with
// programmable ready-delay injection and DECERR/SLVERR/protection decode.
module axi4_lite_slave_responder #(
  parameter int unsigned              ADDRESS_WIDTH   = 32,
  parameter int unsigned              DATA_WIDTH      = 32,
  parameter int unsigned              MEM_DEPTH       = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int unsigned              DELAY_WIDTH     = 5,
  parameter int unsigned              MAX_DELAY_VALUE = 15,
  parameter bit                       PROT_CHECK      = 1'b0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [DELAY_WIDTH-1:0]    cfg_write_ready_delay,
  input  logic [DELAY_WIDTH-1:0]    cfg_read_ready_delay,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDRESS_WIDTH-1:0]  araddr,
  input  logic [2:0]                arprot,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH  = $clog2(MEM_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] MEM_BYTES = ADDRESS_WIDTH'(MEM_DEPTH * STRB_WIDTH);
  localparam logic [DELAY_WIDTH-1:0]   MAX_DELAY = DELAY_WIDTH'(MAX_DELAY_VALUE);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DELAY, W_ACCEPT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_ACCEPT, R_RESP} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DELAY_WIDTH-1:0]   w_cnt, r_cnt, w_delay, r_delay;
  logic [ADDRESS_WIDTH-1:0] aw_off, ar_off;
  logic [IDX_WIDTH-1:0]     aw_idx, ar_idx;
  logic [1:0]               aw_resp, ar_resp;
  logic                     w_accept_q;
  logic                     unused_prot;

  // Only the non-secure bit of AxPROT participates in the decode.
  assign unused_prot = ^{awprot[2], awprot[0], arprot[2], arprot[0]};

  function automatic logic [1:0] decode(input logic [ADDRESS_WIDTH-1:0] addr,
                                        input logic [ADDRESS_WIDTH-1:0] off,
                                        input logic                     nonsecure);
    if (addr < BASE_ADDR || off >= MEM_BYTES)
      return RESP_DECERR;
    if (off[ADDR_LSB-1:0] != '0)
      return RESP_SLVERR;
    if (PROT_CHECK && nonsecure)
      return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [DELAY_WIDTH-1:0] clamp(input logic [DELAY_WIDTH-1:0] cfg);
    return (cfg > MAX_DELAY) ? MAX_DELAY : cfg;
  endfunction

  assign aw_off  = awaddr - BASE_ADDR;
  assign ar_off  = araddr - BASE_ADDR;
  assign aw_idx  = aw_off[ADDR_LSB +: IDX_WIDTH];
  assign ar_idx  = ar_off[ADDR_LSB +: IDX_WIDTH];
  assign aw_resp = decode(awaddr, aw_off, awprot[1]);
  assign ar_resp = decode(araddr, ar_off, arprot[1]);
  assign w_delay = clamp(cfg_write_ready_delay);
  assign r_delay = clamp(cfg_read_ready_delay);

  assign awready = w_accept_q;
  assign wready  = w_accept_q;

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:   if (awvalid && wvalid) w_next = (w_delay == '0) ? W_ACCEPT : W_DELAY;
      W_DELAY:  if (w_cnt <= DELAY_WIDTH'(1)) w_next = W_ACCEPT;
      W_ACCEPT: w_next = W_RESP;
      W_RESP:   if (bready) w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:   if (arvalid) r_next = (r_delay == '0) ? R_ACCEPT : R_DELAY;
      R_DELAY:  if (r_cnt <= DELAY_WIDTH'(1)) r_next = R_ACCEPT;
      R_ACCEPT: r_next = R_RESP;
      R_RESP:   if (rready) r_next = R_IDLE;
      default:  r_next = R_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state    <= W_IDLE;
      w_cnt      <= '0;
      w_accept_q <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
    end else begin
      w_state    <= w_next;
      if (w_state == W_IDLE)
        w_cnt <= w_delay;
      else if (w_state == W_DELAY)
        w_cnt <= w_cnt - DELAY_WIDTH'(1);
      w_accept_q <= (w_next == W_ACCEPT);
      bvalid     <= (w_next == W_RESP);
      if (w_state == W_ACCEPT)
        bresp <= aw_resp;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE)
        r_cnt <= r_delay;
      else if (r_state == R_DELAY)
        r_cnt <= r_cnt - DELAY_WIDTH'(1);
      arready <= (r_next == R_ACCEPT);
      rvalid  <= (r_next == R_RESP);
      // Sampling mem here yields the pre-write value for a same-cycle write.
      if (r_state == R_ACCEPT) begin
        rresp <= ar_resp;
        rdata <= (ar_resp == RESP_OKAY) ? mem[ar_idx] : '0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++)
        mem[i] <= '0;
    end else if (w_state == W_ACCEPT && aw_resp == RESP_OKAY) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++)
        if (wstrb[b])
          mem[aw_idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_responder.sv
// Directed plus randomized bench for axi4_lite_slave_responder against a
// word-array memory model and decode rules expressed as plain arithmetic.
module tb_axi4_lite_slave_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned MAXD  = 15;

  logic        aclk = 1'b0;
  logic        areset;
  logic [4:0]  cfg_write_ready_delay, cfg_read_ready_delay;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned fails = 0;
  logic [31:0] model [DEPTH];

  always #5 aclk = ~aclk;

  axi4_lite_slave_responder #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_DEPTH(16),
    .BASE_ADDR(32'h0),
    .DELAY_WIDTH(5),
    .MAX_DELAY_VALUE(15),
    .PROT_CHECK(1'b1)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cfg_write_ready_delay(cfg_write_ready_delay),
    .cfg_read_ready_delay(cfg_read_ready_delay),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Base address is 0 and the memory spans 64 bytes.
  function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [2:0] prot);
    if (addr >= DEPTH * 4) return 2'b11;
    if (addr % 4 != 0)     return 2'b10;
    if (prot[1])           return 2'b10;
    return 2'b00;
  endfunction

  task automatic check_idle(input string tag);
    chk(tag, {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}, '0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input int unsigned dcfg, input int unsigned hold);
    logic [1:0]  er;
    int unsigned d, n;
    er = exp_resp(addr, prot);
    d  = (dcfg > MAXD) ? MAXD : dcfg;
    cfg_write_ready_delay = 5'(dcfg);
    awaddr = addr; wdata = data; wstrb = strb; awprot = prot;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!awready && n < 64);
    chk("aw_latency", 64'(n), 64'(1 + d));
    chk("wready", wready, 1'b1);
    @(posedge aclk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    if (er == 2'b00)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[5:2]][b*8 +: 8] = data[b*8 +: 8];
    @(negedge aclk);
    chk("bvalid_rise", {awready, wready, bvalid}, 3'b001);
    chk("bresp", bresp, er);
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge aclk);
      chk("b_hold", {bvalid, bresp}, {1'b1, er});
    end
    bready = 1'b1;
    @(posedge aclk);
    #1 bready = 1'b0;
    @(negedge aclk);
    chk("bvalid_fall", bvalid, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] prot,
                         input int unsigned dcfg, input int unsigned hold,
                         output logic [31:0] got);
    logic [1:0]  er;
    logic [31:0] ed;
    int unsigned d, n;
    er = exp_resp(addr, prot);
    ed = (er == 2'b00) ? model[addr[5:2]] : 32'h0;
    d  = (dcfg > MAXD) ? MAXD : dcfg;
    cfg_read_ready_delay = 5'(dcfg);
    araddr = addr; arprot = prot; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!arready && n < 64);
    chk("ar_latency", 64'(n), 64'(1 + d));
    @(posedge aclk);
    #1 arvalid = 1'b0;
    @(negedge aclk);
    chk("rvalid_rise", {arready, rvalid}, 2'b01);
    chk("rresp", rresp, er);
    chk("rdata", rdata, ed);
    got = rdata;
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge aclk);
      chk("r_hold", {rvalid, rresp, rdata}, {1'b1, er, ed});
    end
    rready = 1'b1;
    @(posedge aclk);
    #1 rready = 1'b0;
    @(negedge aclk);
    chk("rvalid_fall", rvalid, 1'b0);
  endtask

  task automatic check_all_mem();
    logic [31:0] got;
    for (int unsigned i = 0; i < DEPTH; i++)
      do_read(32'(i * 4), 3'b000, 0, 0, got);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, rd_a, addr, data;
    logic [2:0]  prot;
    logic        seen;

    areset = 1'b1;
    cfg_write_ready_delay = '0; cfg_read_ready_delay = '0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) @(negedge aclk);
    check_idle("reset_outputs");
    areset = 1'b0;
    @(negedge aclk);

    do_write(32'h4, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0);
    do_read(32'h4, 3'b000, 0, 0, got);
    chk("deadbeef", got, 32'hDEADBEEF);

    do_write(32'h8, 32'hCAFE0008, 4'hF, 3'b000, 31, 0);

    do_write(32'h0, 32'h11223344, 4'hF, 3'b000, 0, 0);
    do_write(32'h0, 32'hAABBCCDD, 4'h5, 3'b000, 2, 0);
    do_read(32'h0, 3'b000, 3, 0, got);
    chk("strobe_merge", got, 32'h11BB33DD);

    do_write(32'h40, 32'h12345678, 4'hF, 3'b000, 0, 0);
    do_write(32'h2, 32'h12345678, 4'hF, 3'b000, 0, 0);
    do_write(32'h4, 32'h12345678, 4'hF, 3'b010, 0, 0);
    do_read(32'h40, 3'b000, 0, 0, got);
    do_read(32'h6, 3'b000, 0, 0, got);
    do_read(32'h8, 3'b010, 0, 0, got);
    do_write(32'h14, 32'h87654321, 4'h0, 3'b000, 1, 0);
    check_all_mem();

    do_write(32'hC, 32'h0, 4'hF, 3'b000, 0, 0);
    fork
      do_write(32'hC, 32'h55, 4'hF, 3'b000, 0, 0);
      do_read(32'hC, 3'b000, 0, 0, rd_a);
    join
    chk("same_cycle_old", rd_a, 32'h0);
    do_read(32'hC, 3'b000, 0, 0, got);
    chk("later_read_new", got, 32'h55);

    fork
      do_write(32'h20, 32'h0BADF00D, 4'hF, 3'b000, 0, 10);
      do_read(32'h4, 3'b000, 1, 0, got);
    join

    for (int unsigned it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'($urandom_range(64, 255));
        1:       addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        default: addr = 32'($urandom_range(0, 15) * 4);
      endcase
      prot = ($urandom_range(0, 3) == 0) ? 3'b010 : (3'($urandom_range(0, 7)) & 3'b101);
      data = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(addr, data, 4'($urandom_range(0, 15)), prot,
                 $urandom_range(0, 20), $urandom_range(0, 3));
      else
        do_read(addr, prot, $urandom_range(0, 20), $urandom_range(0, 3), got);
    end
    check_all_mem();

    cfg_write_ready_delay = 5'd10;
    awaddr = 32'h10; wdata = 32'hFFFF0000; wstrb = 4'hF; awprot = 3'b000;
    awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b1;
    @(posedge aclk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    check_idle("reset_in_delay");
    areset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge aclk);
      seen = seen | bvalid | awready;
    end
    chk("no_resp_after_reset", seen, 1'b0);
    check_all_mem();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
